// File: rtl/can_bit_timing_fsm.sv
// CAN bit-timing generator: divides clk into time quanta, sequences SYNC/PROP/PH1/PH2
// and issues sample/transmit strobes with hard sync and SJW-limited resynchronisation.
module can_bit_timing_fsm #(
    parameter int PRESCALE = 4,
    parameter int SJW      = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] sync_seg,
    input  logic [7:0] prop_seg,
    input  logic [7:0] phase_seg1,
    input  logic [7:0] phase_seg2,
    input  logic       rx,
    input  logic       hard_sync_en,
    output logic       tq_tick,
    output logic       sample_pt,
    output logic       sampled_bit,
    output logic       tx_pt,
    output logic [1:0] seg_state
);

    localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
    localparam logic [8:0]    SJW9 = 9'(SJW);

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        PROP = 2'd1,
        PH1  = 2'd2,
        PH2  = 2'd3
    } seg_t;

    seg_t          state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [8:0]    cnt_q, cnt_d;
    logic          rx_q;
    logic          resync_done_q, resync_done_d;
    logic          sampled_q, sampled_d;

    logic [8:0]    sync_len_q, prop_len_q, ph1_len_q, ph2_len_q;
    logic [8:0]    sync_len, prop_len, ph1_len, ph2_len;
    logic [8:0]    ph1_len_d, ph2_len_d;
    logic [8:0]    cur_len;

    logic          load, tick, edge_ev, hard_ev, resync_ev, seg_end;

    function automatic logic [8:0] len_of(input logic [7:0] v);
        return (v == 8'd0) ? 9'd1 : {1'b0, v};
    endfunction

    function automatic logic [8:0] sat_add9(input logic [8:0] a, input logic [8:0] b);
        logic [9:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[9] ? 9'h1FF : s[8:0];
    endfunction

    function automatic logic [8:0] floor_sub9(input logic [8:0] a, input logic [8:0] b);
        return (a > b) ? (a - b) : 9'd0;
    endfunction

    function automatic logic [8:0] min9(input logic [8:0] a, input logic [8:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [8:0] max9(input logic [8:0] a, input logic [8:0] b);
        return (a > b) ? a : b;
    endfunction

    // The first cycle in SYNC (after reset, en, hard sync or a normal bit end)
    // takes fresh lengths straight from the inputs so even PRESCALE=1 sees them.
    always_comb begin
        load     = (state_q == SYNC) && (cnt_q == 9'd0) && (presc_q == '0);
        sync_len = load ? len_of(sync_seg)   : sync_len_q;
        prop_len = load ? len_of(prop_seg)   : prop_len_q;
        ph1_len  = load ? len_of(phase_seg1) : ph1_len_q;
        ph2_len  = load ? len_of(phase_seg2) : ph2_len_q;
    end

    always_comb begin
        tick      = en && !rst && (presc_q == PMAX);
        edge_ev   = en && !rx && rx_q;
        hard_ev   = edge_ev && hard_sync_en;
        resync_ev = edge_ev && !hard_sync_en && !resync_done_q;
        case (state_q)
            SYNC:    cur_len = sync_len;
            PROP:    cur_len = prop_len;
            PH1:     cur_len = ph1_len;
            default: cur_len = ph2_len;
        endcase
        // >= rather than == so a PH2 shortened below the running count still ends
        seg_end = tick && (cnt_q >= cur_len - 9'd1);
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        presc_d       = tick ? '0 : presc_q + PW'(1);
        resync_done_d = resync_done_q;
        sampled_d     = sampled_q;
        ph1_len_d     = ph1_len;
        ph2_len_d     = ph2_len;
        sample_pt     = 1'b0;
        tx_pt         = 1'b0;

        if (hard_ev) begin
            state_d       = SYNC;
            cnt_d         = 9'd0;
            presc_d       = '0;
            resync_done_d = 1'b0;
        end else begin
            if (resync_ev) begin
                resync_done_d = 1'b1;
                case (state_q)
                    PROP:    ph1_len_d = sat_add9(ph1_len, min9(cnt_q, SJW9));
                    PH1:     ph1_len_d = sat_add9(ph1_len, min9(sat_add9(prop_len, cnt_q), SJW9));
                    PH2:     ph2_len_d = max9(cnt_q + 9'd1, floor_sub9(ph2_len, SJW9));
                    default: ;
                endcase
            end
            if (seg_end) begin
                cnt_d = 9'd0;
                case (state_q)
                    SYNC: state_d = PROP;
                    PROP: state_d = PH1;
                    PH1: begin
                        state_d   = PH2;
                        sample_pt = 1'b1;
                        sampled_d = rx;
                    end
                    default: begin
                        state_d       = SYNC;
                        tx_pt         = 1'b1;
                        resync_done_d = 1'b0;
                    end
                endcase
            end else if (tick) begin
                cnt_d = cnt_q + 9'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= SYNC;
            presc_q       <= '0;
            cnt_q         <= 9'd0;
            rx_q          <= 1'b1;
            resync_done_q <= 1'b0;
            sampled_q     <= 1'b1;
        end else if (!en) begin
            state_q       <= SYNC;
            presc_q       <= '0;
            cnt_q         <= 9'd0;
            rx_q          <= 1'b1;
            resync_done_q <= 1'b0;
            sampled_q     <= 1'b1;
        end else begin
            state_q       <= state_d;
            presc_q       <= presc_d;
            cnt_q         <= cnt_d;
            rx_q          <= rx;
            resync_done_q <= resync_done_d;
            sampled_q     <= sampled_d;
        end
    end

    // Segment lengths are plain data: reloaded every bit, so no reset needed
    always_ff @(posedge clk) begin
        sync_len_q <= sync_len;
        prop_len_q <= prop_len;
        ph1_len_q  <= ph1_len_d;
        ph2_len_q  <= ph2_len_d;
    end

    assign tq_tick     = tick;
    assign sampled_bit = sampled_q;
    assign seg_state   = state_q;

endmodule
